mxdx_router: RTL and testbench

Parametrised, registered successor of the transaction-layer mux/demux.
- Demux side: steers each incoming word into one of FIFO_UNITS class FIFOs, selected by the class field in the word's top bits. It applies backpressure from the FIFOs' almost-full flags.
- Mux side: pops the class FIFOs in round-robin order and presents one word at a time to the downstream stage.
- Sits between the link input and the class FIFO bank, and between that bank and the output stage.

---
 rtl/mxdx_pkg.sv | 23 ++
 rtl/mxdx_rr_arb.sv | 50 +++++
 rtl/mxdx_router.sv | 209 ++++++++++++++++++++
 tb/tb_mxdx_router.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxdx_pkg.sv
// mxdx_pkg
//   Shared definitions for the mxdx_router slice:
//   - mxdx_state_e : mux-side FSM state encoding (IDLE, POP, CAPT)
//   - mxdx_clog2   : ceil(log2(n)), used for the class-field width default
package mxdx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2
    } mxdx_state_e;

    // Number of bits needed to index n distinct values (n >= 2).
    function automatic int mxdx_clog2(input int n);
        int w;
        w = 32'sd0;
        for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mxdx_rr_arb.sv
// mxdx_rr_arb
//   Combinational channel arbiter for the mux side of mxdx_router.
//   Default build: round-robin, the grant is the first requesting channel at
//   or after ptr, wrapping past N-1 back to 0.
//   MXDX_STRICT_PRIO_EN defined: the grant is the lowest-index requesting
//   channel and ptr is ignored.
// Ports:
//   req     in  N   request vector (one bit per non-empty FIFO)
//   ptr     in  PW  round-robin start channel
//   grant   out PW  granted channel index (0 when nothing requests)
//   any_req out 1   at least one channel requests
module mxdx_rr_arb #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any_req
);

    logic [PW-1:0] grant_s;
    logic          found_s;
    int            idx_s;

`ifdef MXDX_STRICT_PRIO_EN
    logic ptr_unused_s;
    assign ptr_unused_s = ^ptr;
`endif

    // Scan channels in priority order; the first requester seen wins.
    always_comb begin
        grant_s = {PW{1'b0}};
        found_s = 1'b0;
        idx_s   = 32'sd0;
        for (int off = 32'sd0; off < N; off++) begin
`ifdef MXDX_STRICT_PRIO_EN
            idx_s = off;
`else
            idx_s = (int'(ptr) + off) % N;
`endif
            grant_s = (req[idx_s] && !found_s) ? PW'(idx_s) : grant_s;
            found_s = found_s | req[idx_s];
        end
    end

    assign grant   = grant_s;
    assign any_req = |req;

endmodule

// File: rtl/mxdx_router.sv
// mxdx_router
//   Demux: routes each accepted input word to the class FIFO named by its top
//   SEL_W bits, with backpressure from the FIFO almost-full flags; words with
//   an out-of-range class are discarded and flagged on drop_err.
//   Mux: pops the class FIFOs one word at a time (IDLE -> POP -> CAPT) and
//   presents each popped word on out_data with a one-cycle out_valid pulse.
//   Build option MXDX_STRICT_PRIO_EN: fixed lowest-index-first grant instead of
//   round-robin; ports and latency unchanged.
// Ports:
//   clk, reset_L                   clock, async active-low reset
//   in_valid, in_data, in_ready    link input handshake (in_ready combinational)
//   push, push_data                one-hot push strobes and per-FIFO data slices
//   fifo_almost_full, fifo_empty   per-FIFO status flags
//   fifo_data_in                   registered FIFO read data (valid after pop)
//   pop                            one-hot pop strobes
//   out_ready, out_valid, out_data downstream word interface
//   drop_err                       one-cycle pulse on illegal-class drop
module mxdx_router
    import mxdx_pkg::*;
#(
    parameter int FIFO_UNITS = 4,
    parameter int WORD_SIZE  = 10,
    parameter int SEL_W      = mxdx_clog2(FIFO_UNITS)
) (
    input  logic                             clk,
    input  logic                             reset_L,
    input  logic                             in_valid,
    input  logic [WORD_SIZE-1:0]             in_data,
    output logic                             in_ready,
    output logic [FIFO_UNITS-1:0]            push,
    output logic [FIFO_UNITS*WORD_SIZE-1:0]  push_data,
    input  logic [FIFO_UNITS-1:0]            fifo_almost_full,
    input  logic [FIFO_UNITS-1:0]            fifo_empty,
    input  logic [FIFO_UNITS*WORD_SIZE-1:0]  fifo_data_in,
    output logic [FIFO_UNITS-1:0]            pop,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [WORD_SIZE-1:0]             out_data,
    output logic                             drop_err
);

    // ---------------- demux side ----------------
    logic [SEL_W-1:0]                dest_s;
    logic                            legal_s;
    logic                            accept_s;
    logic                            in_ready_s;
    logic [FIFO_UNITS-1:0]           push_nxt_s;
    logic [FIFO_UNITS*WORD_SIZE-1:0] push_data_nxt_s;
    logic [FIFO_UNITS-1:0]           push_r;
    logic [FIFO_UNITS*WORD_SIZE-1:0] push_data_r;
    logic                            drop_err_r;

    assign dest_s   = in_data[WORD_SIZE-1 -: SEL_W];
    // Only reachable false when FIFO_UNITS is not a power of two.
    assign legal_s  = (32'(dest_s) < 32'(FIFO_UNITS));
    assign accept_s = in_valid & in_ready_s;

    // Illegal classes are always accepted so they can be dropped.
    always_comb begin
        in_ready_s = 1'b1;
        if (legal_s) begin
            in_ready_s = ~fifo_almost_full[dest_s];
        end else begin
            in_ready_s = 1'b1;
        end
    end

    // Build the next push strobe and data slice for every class FIFO.
    always_comb begin
        push_nxt_s      = {FIFO_UNITS{1'b0}};
        push_data_nxt_s = {(FIFO_UNITS*WORD_SIZE){1'b0}};
        for (int i = 32'sd0; i < FIFO_UNITS; i++) begin
            if (accept_s && legal_s && (dest_s == SEL_W'(i))) begin
                push_nxt_s[i]                           = 1'b1;
                push_data_nxt_s[i*WORD_SIZE +: WORD_SIZE] = in_data;
            end else begin
                push_nxt_s[i]                           = 1'b0;
                push_data_nxt_s[i*WORD_SIZE +: WORD_SIZE] = {WORD_SIZE{1'b0}};
            end
        end
    end

    // Demux output registers: one-cycle push / drop pulses.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_r      <= {FIFO_UNITS{1'b0}};
            push_data_r <= {(FIFO_UNITS*WORD_SIZE){1'b0}};
            drop_err_r  <= 1'b0;
        end else begin
            push_r      <= push_nxt_s;
            push_data_r <= push_data_nxt_s;
            drop_err_r  <= accept_s & ~legal_s;
        end
    end

    // ---------------- mux side ----------------
    mxdx_state_e                 state_r;
    logic [SEL_W-1:0]            grant_r;
    logic [SEL_W-1:0]            rr_ptr_r;
    logic [SEL_W-1:0]            rr_ptr_nxt_s;
    logic [SEL_W-1:0]            arb_ptr_s;
    logic [SEL_W-1:0]            arb_grant_s;
    logic                        arb_any_s;
    logic [FIFO_UNITS-1:0]       req_s;
    logic [FIFO_UNITS-1:0]       grant_onehot_s;
    logic [WORD_SIZE-1:0]        capt_data_s;
    logic [FIFO_UNITS-1:0]       pop_r;
    logic                        out_valid_r;
    logic [WORD_SIZE-1:0]        out_data_r;

    assign req_s = ~fifo_empty;

    // Pointer after the current grant; in CAPT the next grant already uses it.
    always_comb begin
`ifdef MXDX_STRICT_PRIO_EN
        rr_ptr_nxt_s = {SEL_W{1'b0}};
`else
        if (32'(grant_r) == 32'(FIFO_UNITS - 1)) begin
            rr_ptr_nxt_s = {SEL_W{1'b0}};
        end else begin
            rr_ptr_nxt_s = grant_r + SEL_W'(1'b1);
        end
`endif
        if (state_r == ST_CAPT) begin
            arb_ptr_s = rr_ptr_nxt_s;
        end else begin
            arb_ptr_s = rr_ptr_r;
        end
    end

    mxdx_rr_arb #(
        .N  (FIFO_UNITS),
        .PW (SEL_W)
    ) u_arb (
        .req     (req_s),
        .ptr     (arb_ptr_s),
        .grant   (arb_grant_s),
        .any_req (arb_any_s)
    );

    // One-hot pop pattern for the arbiter's grant, and the read-data slice of the held grant.
    always_comb begin
        grant_onehot_s = {FIFO_UNITS{1'b0}};
        capt_data_s    = {WORD_SIZE{1'b0}};
        for (int i = 32'sd0; i < FIFO_UNITS; i++) begin
            grant_onehot_s[i] = (arb_grant_s == SEL_W'(i));
            capt_data_s = (grant_r == SEL_W'(i)) ? fifo_data_in[i*WORD_SIZE +: WORD_SIZE] : capt_data_s;
        end
    end

    // Mux FSM: grant in IDLE/CAPT, pop for one cycle in POP, capture in CAPT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r     <= ST_IDLE;
            grant_r     <= {SEL_W{1'b0}};
            rr_ptr_r    <= {SEL_W{1'b0}};
            pop_r       <= {FIFO_UNITS{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WORD_SIZE{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    if (out_ready && arb_any_s) begin
                        grant_r <= arb_grant_s;
                        pop_r   <= grant_onehot_s;
                        state_r <= ST_POP;
                    end else begin
                        pop_r   <= {FIFO_UNITS{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    pop_r       <= {FIFO_UNITS{1'b0}};
                    out_valid_r <= 1'b0;
                    state_r     <= ST_CAPT;
                end
                ST_CAPT: begin
                    out_data_r  <= capt_data_s;
                    out_valid_r <= 1'b1;
                    rr_ptr_r    <= rr_ptr_nxt_s;
                    // Back-to-back: skip IDLE so streaming runs at one word per two cycles.
                    if (out_ready && arb_any_s) begin
                        grant_r <= arb_grant_s;
                        pop_r   <= grant_onehot_s;
                        state_r <= ST_POP;
                    end else begin
                        pop_r   <= {FIFO_UNITS{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    pop_r       <= {FIFO_UNITS{1'b0}};
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign push      = push_r;
    assign push_data = push_data_r;
    assign drop_err  = drop_err_r;
    assign pop       = pop_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_mxdx_router.sv
// tb_mxdx_router
//   Self-checking bench for mxdx_router: a 4-channel instance fed by a
//   behavioural FIFO bank, and a 3-channel instance for illegal-class drops.
module tb_mxdx_router;

    logic        clk = 1'b0;
    logic        reset_L;

    // 4-channel instance
    logic        in_valid;
    logic [9:0]  in_data;
    logic        in_ready;
    logic [3:0]  push;
    logic [39:0] push_data;
    logic [3:0]  fifo_almost_full;
    logic [3:0]  fifo_empty;
    logic [39:0] fifo_data_in;
    logic [3:0]  pop;
    logic        out_ready;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        drop_err;

    // 3-channel instance
    logic        in_valid3;
    logic [9:0]  in_data3;
    logic        in_ready3;
    logic [2:0]  push3;
    logic [29:0] push_data3;
    logic [2:0]  afull3;
    logic [2:0]  empty3 = 3'b111;
    logic [29:0] rdata3 = 30'd0;
    logic [2:0]  pop3;
    logic        out_ready3 = 1'b0;
    logic        out_valid3;
    logic [9:0]  out_data3;
    logic        drop_err3;

    int errors = 0;
    int checks = 0;

    mxdx_router #(.FIFO_UNITS(4), .WORD_SIZE(10)) dut (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .push(push), .push_data(push_data),
        .fifo_almost_full(fifo_almost_full), .fifo_empty(fifo_empty),
        .fifo_data_in(fifo_data_in), .pop(pop), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .drop_err(drop_err)
    );

    mxdx_router #(.FIFO_UNITS(3), .WORD_SIZE(10)) dut3 (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .push(push3), .push_data(push_data3),
        .fifo_almost_full(afull3), .fifo_empty(empty3),
        .fifo_data_in(rdata3), .pop(pop3), .out_ready(out_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .drop_err(drop_err3)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // ---------- behavioural class-FIFO bank for the 4-channel instance ----------
    logic [9:0] bank_mem [4][64];
    int         bank_head [4];
    int         bank_tail [4];
    logic [9:0] bank_rd [4];

    // Registered read: data appears the cycle after pop is sampled.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && (bank_head[i] != bank_tail[i])) begin
                bank_rd[i]   <= bank_mem[i][bank_head[i] % 64];
                bank_head[i] <= bank_head[i] + 1;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        assign fifo_empty[gi]               = (bank_head[gi] == bank_tail[gi]);
        assign fifo_data_in[gi*10 +: 10]    = bank_rd[gi];
    end

    task automatic load(input int ch, input logic [9:0] w);
        bank_mem[ch][bank_tail[ch] % 64] = w;
        bank_tail[ch] = bank_tail[ch] + 1;
    endtask

    task automatic clear_bank();
        for (int i = 0; i < 4; i++) bank_tail[i] = bank_head[i];
    endtask

    // ---------- reference model: output order of the currently queued words ----------
    logic [9:0] exp_w[$];
    int         exp_c[$];

    // Pointer starts at 0 (fresh reset); each grant takes the first non-empty
    // channel from the pointer, then the pointer moves past the granted channel.
    task automatic build_expected();
        int idx [4];
        int ptr;
        int g;
        int ch;
        exp_w.delete();
        exp_c.delete();
        for (int i = 0; i < 4; i++) idx[i] = bank_head[i];
        ptr = 0;
        for (int guard = 0; guard < 256; guard++) begin
            g = -1;
            for (int off = 0; off < 4; off++) begin
`ifdef MXDX_STRICT_PRIO_EN
                ch = off;
`else
                ch = (ptr + off) % 4;
`endif
                if (g < 0 && idx[ch] < bank_tail[ch]) g = ch;
            end
            if (g < 0) break;
            exp_w.push_back(bank_mem[g][idx[g] % 64]);
            exp_c.push_back(g);
            idx[g] = idx[g] + 1;
            ptr = (g + 1) % 4;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [9:0] data;
        logic [3:0] afull;
        logic       exp_ready;
        logic [3:0] exp_push;
    } dmx_vec_t;

    dmx_vec_t tbl [6];

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [39:0] ed;
        logic [3:0]  ep;
        logic [1:0]  d;
        logic        er;
        int          got;

        tbl[0] = '{1'b1, 10'h2A5, 4'b0000, 1'b1, 4'b0100};
        tbl[1] = '{1'b1, 10'h155, 4'b0010, 1'b0, 4'b0000};
        tbl[2] = '{1'b1, 10'h155, 4'b0000, 1'b1, 4'b0010};
        tbl[3] = '{1'b1, 10'h3FF, 4'b0111, 1'b1, 4'b1000};
        tbl[4] = '{1'b0, 10'h0AB, 4'b0000, 1'b1, 4'b0000};
        tbl[5] = '{1'b1, 10'h0AB, 4'b0001, 1'b0, 4'b0000};

        reset_L = 1'b0;
        in_valid = 1'b1;
        in_data = 10'h2A5;
        fifo_almost_full = 4'b0000;
        out_ready = 1'b0;
        in_valid3 = 1'b0;
        in_data3 = 10'h000;
        afull3 = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_push", push, 4'b0000);
        chk("reset_push_data", push_data, 40'h0);
        chk("reset_pop", pop, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 10'h000);
        chk("reset_drop_err", drop_err, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        reset_L = 1'b1;
        step();

        // Table-driven demux vectors
        for (int v = 0; v < 6; v++) begin
            in_valid = tbl[v].valid;
            in_data = tbl[v].data;
            fifo_almost_full = tbl[v].afull;
            #1;
            chk("tbl_in_ready", in_ready, tbl[v].exp_ready);
            step();
            ed = 40'h0;
            for (int i = 0; i < 4; i++) if (tbl[v].exp_push[i]) ed[i*10 +: 10] = tbl[v].data;
            chk("tbl_push", push, tbl[v].exp_push);
            chk("tbl_push_data", push_data, ed);
            in_valid = 1'b0;
        end
        fifo_almost_full = 4'b0000;

        // Illegal class on the 3-channel instance
        in_valid3 = 1'b1;
        in_data3 = 10'h3C1;
        afull3 = 3'b111;
        #1;
        chk("ill_in_ready", in_ready3, 1'b1);
        step();
        chk("ill_no_push", push3, 3'b000);
        chk("ill_push_data", push_data3, 30'h0);
        chk("ill_drop_err", drop_err3, 1'b1);
        in_valid3 = 1'b0;
        step();
        chk("ill_drop_pulse", drop_err3, 1'b0);
        in_valid3 = 1'b1;
        in_data3 = 10'h2A5;
        afull3 = 3'b000;
        step();
        chk("ill_legal_push", push3, 3'b100);
        chk("ill_legal_data", push_data3, {10'h2A5, 20'h0});
        chk("ill_legal_drop", drop_err3, 1'b0);
        in_valid3 = 1'b0;

        // Randomized demux against the class-routing rule
        for (int k = 0; k < 150; k++) begin
            in_valid = 1'($urandom_range(1, 0));
            in_data = 10'($urandom);
            fifo_almost_full = 4'($urandom);
            #1;
            d = in_data[9:8];
            er = ~fifo_almost_full[d];
            chk("rnd_in_ready", in_ready, er);
            ep = 4'b0000;
            ed = 40'h0;
            if (in_valid && er) begin
                ep[d] = 1'b1;
                ed[d*10 +: 10] = in_data;
            end
            step();
            chk("rnd_push", {20'h0, push, push_data}, {20'h0, ep, ed});
            chk("rnd_drop_err", drop_err, 1'b0);
        end
        in_valid = 1'b0;
        fifo_almost_full = 4'b0000;

        // Streaming round-robin: two words per channel, pops every other cycle
        reset_L = 1'b0;
        step();
        clear_bank();
        reset_L = 1'b1;
        step();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 2; k++) load(ch, 10'(ch * 256 + k * 16 + 5));
        build_expected();
        out_ready = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if ((c % 2 == 1) && (c <= 9)) chk("rr_pop", pop, 64'd1 << exp_c[(c - 1) / 2]);
            else chk("rr_pop_low", pop, 4'b0000);
            if ((c % 2 == 1) && (c >= 3)) begin
                chk("rr_out_valid", out_valid, 1'b1);
                chk("rr_out_data", out_data, exp_w[(c - 3) / 2]);
            end else begin
                chk("rr_out_valid_low", out_valid, 1'b0);
            end
            if (c == 9) out_ready = 1'b0;
        end

        // Reset while pop is high on channel 3
        clear_bank();
        load(3, 10'h3AA);
        out_ready = 1'b1;
        step();
        chk("rp_pop_ch3", pop, 4'b1000);
        #2;
        reset_L = 1'b0;
        #1;
        chk("rp_pop_dropped", pop, 4'b0000);
        chk("rp_out_valid", out_valid, 1'b0);
        chk("rp_out_data", out_data, 10'h000);
        out_ready = 1'b0;
        step();
        step();
        reset_L = 1'b1;
        step();
        chk("rp_out_valid_after", out_valid, 1'b0);
        load(0, 10'h0BB);
        out_ready = 1'b1;
        step();
        chk("rp_ptr_zero_pop", pop, 4'b0001);
        step();
        step();
        chk("rp_out_valid_first", out_valid, 1'b1);
        chk("rp_out_data_first", out_data, 10'h0BB);
        out_ready = 1'b0;
        repeat (5) step();

        // Randomized drain with random out_ready against the queue model
        for (int round = 0; round < 3; round++) begin
            reset_L = 1'b0;
            step();
            clear_bank();
            reset_L = 1'b1;
            step();
            for (int ch = 0; ch < 4; ch++) begin
                int n;
                n = $urandom_range(6, 0);
                for (int j = 0; j < n; j++) load(ch, 10'($urandom));
            end
            build_expected();
            got = 0;
            for (int cyc = 0; cyc < 400 && got < exp_w.size(); cyc++) begin
                out_ready = 1'($urandom_range(1, 0));
                step();
                chk("drain_pop_onehot", {63'h0, $onehot0(pop)}, 64'd1);
                if (out_valid) begin
                    if (got < exp_w.size()) chk("drain_out_data", out_data, exp_w[got]);
                    got++;
                end
            end
            chk("drain_count", got, exp_w.size());
            out_ready = 1'b1;
            for (int j = 0; j < 6; j++) begin
                step();
                chk("drain_no_extra", out_valid, 1'b0);
            end
            out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
